// File: rtl/sw_ctrl_pkg.sv
// rtl/sw_ctrl_pkg.sv - shared state encoding for the stopwatch run-control block
package sw_ctrl_pkg;

  localparam int ST_W = 2;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_LAP   = 2'd3
  } sw_state_e;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - 2-flop synchronizer, stability counter and registered press pulse
module btn_debounce #(
  parameter int DEB_CYCLES = 20,
  parameter int DEB_W      = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic press
);

  localparam logic [DEB_W-1:0] CNT_LAST = DEB_W'(DEB_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             level_dly_q;
  logic             press_q;
  logic [DEB_W-1:0] cnt_q, cnt_d;

  // Level flips on the DEB_CYCLES-th consecutive cycle that sync2 disagrees with it.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      cnt_q       <= '0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      press_q     <= 1'b0;
    end else begin
      sync1_q     <= raw;
      sync2_q     <= sync1_q;
      cnt_q       <= cnt_d;
      level_q     <= level_d;
      level_dly_q <= level_q;
      press_q     <= level_q & ~level_dly_q;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - debounced start/stop and lap/reset run-control FSM for the counter chain
module stopwatch_ctrl
  import sw_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = 20,
  parameter int DEB_W      = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            btn_ss,
  input  logic            btn_lap,
  input  logic            cnt_ovf,
  output logic            cnt_en,
  output logic            cnt_clr,
  output logic            lap_cap,
  output logic            disp_hold,
  output logic [ST_W-1:0] state
);

  logic      ss_press, lap_press;
  sw_state_e state_q, state_d;
  logic      cnt_en_q, cnt_clr_q, lap_cap_q, disp_hold_q;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_deb_ss (
    .clk  (clk),
    .rst  (rst),
    .raw  (btn_ss),
    .press(ss_press)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_deb_lap (
    .clk  (clk),
    .rst  (rst),
    .raw  (btn_lap),
    .press(lap_press)
  );

  // Overflow beats start/stop beats lap; a losing press is simply dropped.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (ss_press) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (cnt_ovf || ss_press) state_d = ST_PAUSE;
        else if (lap_press)      state_d = ST_LAP;
      end
      ST_LAP: begin
        if (cnt_ovf || ss_press) state_d = ST_PAUSE;
        else if (lap_press)      state_d = ST_RUN;
      end
      ST_PAUSE: begin
        if (ss_press)       state_d = ST_RUN;
        else if (lap_press) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_en_q    <= 1'b0;
      cnt_clr_q   <= 1'b0;
      lap_cap_q   <= 1'b0;
      disp_hold_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_en_q    <= (state_d == ST_RUN) || (state_d == ST_LAP);
      cnt_clr_q   <= (state_q == ST_PAUSE) && (state_d == ST_IDLE);
      lap_cap_q   <= (state_q == ST_RUN) && (state_d == ST_LAP);
      disp_hold_q <= (state_d == ST_LAP);
    end
  end

  assign cnt_en    = cnt_en_q;
  assign cnt_clr   = cnt_clr_q;
  assign lap_cap   = lap_cap_q;
  assign disp_hold = disp_hold_q;
  assign state     = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - scoreboard bench: expected output changes queued with their cycle
module tb_stopwatch_ctrl;

  typedef struct {
    int         cyc;
    logic [5:0] vec;
  } exp_t;

  // vec = {state[1:0], cnt_en, cnt_clr, lap_cap, disp_hold}
  localparam logic [5:0] V_IDLE  = 6'b00_0000;
  localparam logic [5:0] V_CLR   = 6'b00_0100;
  localparam logic [5:0] V_RUN   = 6'b01_1000;
  localparam logic [5:0] V_PAUSE = 6'b10_0000;
  localparam logic [5:0] V_LAPC  = 6'b11_1011;
  localparam logic [5:0] V_LAP   = 6'b11_1001;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_ss = 1'b0;
  logic       btn_lap = 1'b0;
  logic       cnt_ovf = 1'b0;
  logic       cnt_en, cnt_clr, lap_cap, disp_hold;
  logic [1:0] state;

  int         cyc = 0;
  int         n_cmp = 0;
  int         n_err = 0;
  bit         mon_en = 1'b0;
  logic [5:0] prev_obs = 6'b0;
  exp_t       sb[$];

  stopwatch_ctrl #(.DEB_CYCLES(4), .DEB_W(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_ss   (btn_ss),
    .btn_lap  (btn_lap),
    .cnt_ovf  (cnt_ovf),
    .cnt_en   (cnt_en),
    .cnt_clr  (cnt_clr),
    .lap_cap  (lap_cap),
    .disp_hold(disp_hold),
    .state    (state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    logic [5:0] obs;
    exp_t       e;
    obs = {state, cnt_en, cnt_clr, lap_cap, disp_hold};
    if (mon_en && (obs !== prev_obs)) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_change cyc=%0d got=%b expected no change", cyc, obs);
      end else begin
        e = sb.pop_front();
        if (e.vec !== obs || e.cyc != cyc) begin
          n_err++;
          $display("FAIL out_change got=%b@%0d expected=%b@%0d", obs, cyc, e.vec, e.cyc);
        end
      end
      prev_obs = obs;
    end
  end

  task automatic expect_at(input int c, input logic [5:0] v);
    exp_t e;
    e.cyc = c;
    e.vec = v;
    sb.push_back(e);
  endtask

  task automatic ticks(input int k);
    repeat (k) @(negedge clk);
  endtask

  // Called at a negedge; first sample is the next posedge, action lands 8 edges after n.
  task automatic press(input bit ss, input bit lap, input bit ovf, input int hold, output int n);
    n = cyc;
    btn_ss  = ss;
    btn_lap = lap;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      cnt_ovf = ovf && (cyc == n + 7);
    end
    cnt_ovf = 1'b0;
    btn_ss  = 1'b0;
    btn_lap = 1'b0;
    ticks(12);
  endtask

  initial begin
    int n;
    ticks(3);
    n_cmp++;
    if ({state, cnt_en, cnt_clr, lap_cap, disp_hold} !== V_IDLE) begin
      n_err++;
      $display("FAIL reset_state got=%b expected=%b", {state, cnt_en, cnt_clr, lap_cap, disp_hold}, V_IDLE);
    end
    rst      = 1'b1;
    prev_obs = V_IDLE;
    mon_en   = 1'b1;
    ticks(2);

    // 1: start after full debounce latency
    n = cyc; expect_at(n + 8, V_RUN);
    press(1, 0, 0, 10, n);

    // 2: short glitches are filtered
    for (int i = 0; i < 5; i++) begin
      btn_ss = 1'b1; ticks(3);
      btn_ss = 1'b0; ticks(3);
    end
    ticks(10);

    // 3: lap in and out
    n = cyc; expect_at(n + 8, V_LAPC); expect_at(n + 9, V_LAP);
    press(0, 1, 0, 9, n);
    n = cyc; expect_at(n + 8, V_RUN);
    press(0, 1, 0, 9, n);

    // 4: pause, clear, lap ignored in IDLE
    n = cyc; expect_at(n + 8, V_PAUSE);
    press(1, 0, 0, 9, n);
    n = cyc; expect_at(n + 8, V_CLR); expect_at(n + 9, V_IDLE);
    press(0, 1, 0, 9, n);
    press(0, 1, 0, 9, n);

    // 5: overflow and start/stop both beat lap
    n = cyc; expect_at(n + 8, V_RUN);
    press(1, 0, 0, 9, n);
    n = cyc; expect_at(n + 8, V_PAUSE);
    press(0, 1, 1, 9, n);
    n = cyc; expect_at(n + 8, V_RUN);
    press(1, 0, 0, 9, n);
    n = cyc; expect_at(n + 8, V_PAUSE);
    press(1, 1, 0, 9, n);

    // 6: reset while in LAP, then a button held across reset
    n = cyc; expect_at(n + 8, V_RUN);
    press(1, 0, 0, 9, n);
    n = cyc; expect_at(n + 8, V_LAPC); expect_at(n + 9, V_LAP);
    press(0, 1, 0, 9, n);
    n = cyc; expect_at(n + 1, V_IDLE);
    rst = 1'b0; ticks(1); rst = 1'b1;
    ticks(5);
    btn_ss = 1'b1;
    ticks(2);
    n = cyc; expect_at(n + 9, V_RUN);
    rst = 1'b0; ticks(1); rst = 1'b1;
    ticks(20);
    btn_ss = 1'b0;
    ticks(20);

    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain got=%0d pending expected=0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
